// File: rtl/minigame_scheduler.sv
// Match sequencer for the minigame output mux: menu, start pulse, scoring.
// Optional PLAYING watchdog enabled by defining MINIGAME_TIMEOUT_EN.
module minigame_scheduler #(
    parameter int NUM_RODADAS = 3,
    parameter int PONT_W      = 5
`ifdef MINIGAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50_000_000
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              confirma,
    input  logic [1:0]        selecao,
    input  logic              pronto_in,
    input  logic [2:0]        pontuacao_in,
    output logic [1:0]        minigame,
    output logic [2:0]        inicia,
    output logic [3:0]        estado_inicial,
    output logic [PONT_W-1:0] pontuacao_total,
    output logic [3:0]        rodada,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MENU    = 3'd1,
        S_START   = 3'd2,
        S_PLAYING = 3'd3,
        S_DONE    = 3'd4,
        S_FIM     = 3'd5
`ifdef MINIGAME_TIMEOUT_EN
        ,
        S_TIMEOUT = 3'd6
`endif
    } state_t;

    state_t             state;
    logic [1:0]         sel_r;
    logic               iniciar_q;
    logic               confirma_q;
    logic               ini_edge;
    logic               conf_edge;
    logic [3:0]         rodada_inc;
    logic               last_round;
    logic [PONT_W:0]    soma;
    logic [PONT_W-1:0]  soma_sat;

`ifdef MINIGAME_TIMEOUT_EN
    logic [25:0]        cnt;
    logic               timeout_r;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    assign ini_edge   = iniciar & ~iniciar_q;
    assign conf_edge  = confirma & ~confirma_q;
    assign rodada_inc = rodada + 4'd1;
    assign last_round = (rodada_inc == 4'(NUM_RODADAS));
    assign soma       = {1'b0, pontuacao_total} + (PONT_W+1)'(pontuacao_in);
    assign soma_sat   = soma[PONT_W] ? '1 : soma[PONT_W-1:0];

    // State code is itself a register, so this output stays registered.
    assign estado_inicial = {1'b0, state};

    // Sequencer FSM with registered mux select, start pulse and totals.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= S_IDLE;
            sel_r           <= 2'd0;
            iniciar_q       <= 1'b0;
            confirma_q      <= 1'b0;
            minigame        <= 2'b11;
            inicia          <= 3'b000;
            pontuacao_total <= '0;
            rodada          <= 4'd0;
`ifdef MINIGAME_TIMEOUT_EN
            cnt             <= 26'd0;
            timeout_r       <= 1'b0;
`endif
        end else begin
            iniciar_q  <= iniciar;
            confirma_q <= confirma;
            inicia     <= 3'b000;
            unique case (state)
                S_IDLE: begin
                    minigame <= 2'b11;
                    if (ini_edge)
                        state <= S_MENU;
                end
                S_MENU: begin
                    minigame <= 2'b11;
                    if (conf_edge && selecao != 2'b11) begin
                        sel_r    <= selecao;
                        minigame <= selecao;
                        inicia   <= 3'b001 << selecao;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    minigame <= sel_r;
                    state    <= S_PLAYING;
`ifdef MINIGAME_TIMEOUT_EN
                    cnt      <= 26'd0;
`endif
                end
                S_PLAYING: begin
                    minigame <= sel_r;
                    if (pronto_in)
                        state <= S_DONE;
`ifdef MINIGAME_TIMEOUT_EN
                    else if (cnt == 26'(TIMEOUT_CYCLES - 1))
                        state <= S_TIMEOUT;
                    else
                        cnt <= cnt + 26'd1;
`endif
                end
                S_DONE: begin
                    minigame        <= 2'b11;
                    pontuacao_total <= soma_sat;
                    rodada          <= rodada_inc;
                    state           <= last_round ? S_FIM : S_MENU;
                end
`ifdef MINIGAME_TIMEOUT_EN
                S_TIMEOUT: begin
                    minigame  <= 2'b11;
                    timeout_r <= 1'b1;
                    rodada    <= rodada_inc;
                    state     <= last_round ? S_FIM : S_MENU;
                end
`endif
                S_FIM: begin
                    minigame <= 2'b11;
                    if (ini_edge) begin
                        pontuacao_total <= '0;
                        rodada          <= 4'd0;
`ifdef MINIGAME_TIMEOUT_EN
                        timeout_r       <= 1'b0;
`endif
                        state           <= S_MENU;
                    end
                end
                default: begin
                    minigame <= 2'b11;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
